// File: rtl/kyber_uop_dispatch.sv
// Micro-op dispatcher: accepts one command at a time, launches the mapped execution unit
// and returns a single cmd_done per accepted command, with sticky error reporting.
module kyber_uop_dispatch #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd_op,
    input  logic [4:0] cmd_slot_a,
    input  logic [4:0] cmd_slot_b,
    input  logic [3:0] cmd_param,
    input  logic       cmd_start,
    output logic       cmd_done,
    output logic       busy,
    output logic [5:0] unit_start,
    input  logic [5:0] unit_done,
    output logic [3:0] unit_op,
    output logic [4:0] unit_slot_a,
    output logic [4:0] unit_slot_b,
    output logic [3:0] unit_param,
    output logic       err_illegal,
    output logic       err_timeout,
    output logic       err_overrun,
    input  logic       err_clr
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0]  sel_q, sel_d;
    logic [5:0]  start_q, start_d;
    logic        done_q, done_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  slot_a_q, slot_a_d;
    logic [4:0]  slot_b_q, slot_b_d;
    logic [3:0]  param_q, param_d;
    logic        ill_q, ill_d;
    logic        tmo_q, tmo_d;
    logic        ovr_q, ovr_d;
    logic        ill_set, tmo_set, ovr_set;
    logic [5:0]  dec_onehot;
    logic        dec_illegal;
    logic        done_hit;

    always_comb begin
        dec_onehot  = 6'b000000;
        dec_illegal = 1'b0;
        case (cmd_op)
            4'd1, 4'd2, 4'd4, 4'd5, 4'd6: dec_onehot = 6'b000001;
            4'd3:                         dec_onehot = 6'b000010;
            4'd7:                         dec_onehot = 6'b000100;
            4'd8, 4'd9:                   dec_onehot = 6'b001000;
            4'd10, 4'd11:                 dec_onehot = 6'b010000;
            4'd12:                        dec_onehot = 6'b100000;
            4'd0:                         dec_onehot = 6'b000000;
            default:                      dec_illegal = 1'b1;
        endcase
    end

    // Only the launched unit's done bit can complete the command.
    assign done_hit = |(unit_done & sel_q);
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        start_d  = 6'b000000;
        done_d   = 1'b0;
        op_d     = op_q;
        slot_a_d = slot_a_q;
        slot_b_d = slot_b_q;
        param_d  = param_q;
        ill_set  = 1'b0;
        tmo_set  = 1'b0;
        ovr_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    op_d     = cmd_op;
                    slot_a_d = cmd_slot_a;
                    slot_b_d = cmd_slot_b;
                    param_d  = cmd_param;
                    if (dec_onehot != 6'b000000) begin
                        start_d = dec_onehot;
                        sel_d   = dec_onehot;
                        cnt_d   = 16'd0;
                        state_d = StWait;
                    end else begin
                        ill_set = dec_illegal;
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                ovr_set = cmd_start;
                // Completion returns straight to idle with a registered cmd_done, so the
                // pulse lands one cycle after unit_done and busy is already low with it.
                if (done_hit) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if ((TIMEOUT_CYCLES != 16'd0) && (cnt_inc == TIMEOUT_CYCLES)) begin
                    tmo_set = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                ovr_set = cmd_start;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A set event in the same cycle beats err_clr.
        ill_d = ill_set | (ill_q & ~err_clr);
        tmo_d = tmo_set | (tmo_q & ~err_clr);
        ovr_d = ovr_set | (ovr_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 16'd0;
            sel_q    <= 6'b000000;
            start_q  <= 6'b000000;
            done_q   <= 1'b0;
            op_q     <= 4'd0;
            slot_a_q <= 5'd0;
            slot_b_q <= 5'd0;
            param_q  <= 4'd0;
            ill_q    <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
            done_q   <= done_d;
            op_q     <= op_d;
            slot_a_q <= slot_a_d;
            slot_b_q <= slot_b_d;
            param_q  <= param_d;
            ill_q    <= ill_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign cmd_done    = done_q;
    assign unit_start  = start_q;
    assign unit_op     = op_q;
    assign unit_slot_a = slot_a_q;
    assign unit_slot_b = slot_b_q;
    assign unit_param  = param_q;
    assign err_illegal = ill_q;
    assign err_timeout = tmo_q;
    assign err_overrun = ovr_q;

endmodule

// File: doc/kyber_uop_dispatch.md
KYBER_UOP_DISPATCH -- requirements
Module: kyber_uop_dispatch

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 16'd65535, max WAIT cycles before forced completion; 0 disables timeout.
REQ-002 SHALL provide ports: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL provide ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide ports: cmd_op  input  4  micro-op opcode; cmd_slot_a  input  5; cmd_slot_b  input  5; cmd_param  input  4.
REQ-005 SHALL provide ports: cmd_start  input  1  one-cycle command strobe; cmd_done  output  1  one-cycle completion pulse; busy  output  1  command in flight.
REQ-006 SHALL provide ports: unit_start  output  6  one-hot unit launch pulse; unit_done  input  6  per-unit completion.
REQ-007 SHALL provide ports: unit_op  output  4; unit_slot_a  output  5; unit_slot_b  output  5; unit_param  output  4; these are the latched command fields.
REQ-008 SHALL provide ports: err_illegal  output  1; err_timeout  output  1; err_overrun  output  1; all sticky.
REQ-009 SHALL provide ports: err_clr  input  1  clears sticky errors.

Function
REQ-010 SHALL be the responder end of the micro-op command handshake: accept cmd_* and return exactly one cmd_done per accepted command.
REQ-011 SHALL map opcodes to unit index: 1,2,4,5,6 -> 0 (copy); 3 -> 1 (NTT); 7 -> 2 (basemul); 8,9 -> 3 (poly ALU); 10,11 -> 4 (compress/decompress); 12 -> 5 (CBD); 0 = NOP; 13-15 = illegal.
REQ-012 SHALL implement states IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-013 SHALL accept a command only when cmd_start=1 in IDLE (sampled cycle T), latching all four fields into unit_* at that edge.
REQ-014 SHALL, for a unit-mapped opcode, drive unit_start[idx]=1 for cycle T+1 only and enter WAIT.
REQ-015 SHALL, for NOP or an illegal opcode, assert no unit_start, enter RESP at T+1, pulse cmd_done at T+2; illegal additionally sets err_illegal.
REQ-016 SHALL in WAIT (from T+1 on) monitor only unit_done[idx]; done bits of other units are ignored.
REQ-017 SHALL, when unit_done[idx]=1 is sampled in WAIT at cycle D, enter RESP and pulse cmd_done in cycle D+1.
REQ-018 SHALL leave RESP for IDLE after one cycle; cmd_done is high exactly one cycle and busy falls in the cycle cmd_done is high.
REQ-019 SHALL count WAIT cycles in a 16-bit counter cleared on entry; when TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES without unit_done, set err_timeout and proceed to RESP (cmd_done still pulses).
REQ-020 SHALL ignore cmd_start while busy and set err_overrun; unit_* fields remain unchanged.
REQ-021 SHALL accept a cmd_start in the same cycle cmd_done is high (state already IDLE).
REQ-022 SHALL hold unit_op/slot/param stable from acceptance until the next acceptance.
REQ-023 SHALL clear all three error flags on err_clr; a set event in the same cycle wins over err_clr.
REQ-024 SHALL keep unit_start all-zero except the single pulse cycle; never more than one bit set.

Reset
REQ-025 SHALL on rst=1 asynchronously force state IDLE, WAIT counter 0, cmd_done=0, busy=0, unit_start=0, unit_op/slot_a/slot_b/param=0, all error flags 0.
REQ-026 SHALL on reset mid-WAIT abandon the command without emitting cmd_done; execution units are reset by the same rst.

Verification
REQ-027 SHALL cover: cmd_op=3, slot_a=2, param=1 at T; unit_done[1] at T+40 -> unit_start=6'b000010 at T+1, cmd_done at T+41, unit_slot_a=2 held throughout.
REQ-028 SHALL cover: cmd_op=0 at T -> cmd_done at T+2, no unit_start; then cmd_op=14 -> cmd_done two cycles later, err_illegal=1.
REQ-029 SHALL cover: TIMEOUT_CYCLES=8, cmd_op=7, unit_done never -> err_timeout=1 and cmd_done after 8 WAIT cycles; err_clr -> err_timeout=0.
REQ-030 SHALL cover: cmd_start during WAIT with cmd_op=9 -> ignored, err_overrun=1, unit_op unchanged; stray unit_done[0] during a basemul WAIT -> no cmd_done.
REQ-031 SHALL cover: replay of the 32-step decrypt sequence against a unit model with random 1-50 cycle latencies -> 32 cmd_done pulses, correct one-hot per step, no errors.
REQ-032 SHALL cover: rst asserted mid-WAIT -> all outputs 0 immediately; next cmd_op=10 accepted normally after release.
